// File: rtl/addsub_seq.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// addsub_seq
//
// Byte-serial two's-complement adder/subtractor. An accepted operation is
// worked through one byte per clock, LSB first, on a single 8-bit
// adder slice. After the last byte the W-bit result, the signed overflow
// flag and the carry out of the top bit are held until the consumer takes
// them.
//
// Parameters
//   BYTES        operand width in bytes (2..8)
//   W            derived data width, 8*BYTES
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  requester presents an operation
//   start_ready  block can accept an operation (IDLE only)
//   a, b         operands, two's complement
//   opcode       0 = a + b, 1 = a - b
//   res_valid    s / is_overflow / cout are valid (DONE only)
//   res_ready    consumer accepts the result
//   s            sum or difference, modulo 2^W
//   is_overflow  signed overflow of the W-bit operation
//   cout         carry out of bit W-1 (subtract: 1 = no borrow)
//   busy         high while an operation is in RUN or DONE
//   state_dbg    current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both 1. start_ready is high only in IDLE;
// res_valid is high only in DONE. A result is never bypassed into a new
// start in the same cycle: after the result transfer the block spends one
// cycle in IDLE before the next operation can be taken.
// -----------------------------------------------------------------------------
module addsub_seq #(
    parameter  int BYTES = 4,
    localparam int W     = 8 * BYTES
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         opcode,

    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] s,
    output logic         is_overflow,
    output logic         cout,

    output logic         busy,
    output logic [1:0]   state_dbg
);

    // Index into the operand bytes; BYTES >= 2 keeps this at least 1 bit.
    localparam int IW = $clog2(BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;

    // Operation context latched at accept.
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            op_r;

    // Datapath state.
    logic [W-1:0]    s_r;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            ovf_r;
    logic            cout_r;

    // Byte slice signals.
    logic [IW+2:0]   bit_off;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      low_sum;
    logic [1:0]      top_sum;
    logic [7:0]      s_byte;
    logic            c_into_msb;
    logic            c_out_msb;

    // Bit offset of the current byte: idx * 8.
    assign bit_off = {idx, 3'b000};

    // One 8-bit slice. For subtraction B is inverted and the initial carry
    // (set to opcode at accept) supplies the +1 of the two's complement.
    // The slice is split at bit 7 so the carry into the slice MSB is
    // available: on the final byte that is the carry into bit W-1, which
    // together with the carry out gives the signed overflow.
    always_comb begin
        a_byte     = a_r[bit_off +: 8];
        b_byte     = b_r[bit_off +: 8] ^ {8{op_r}};
        low_sum    = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'd0, carry};
        c_into_msb = low_sum[7];
        top_sum    = {1'b0, a_byte[7]} + {1'b0, b_byte[7]} + {1'b0, c_into_msb};
        c_out_msb  = top_sum[1];
        s_byte     = {top_sum[0], low_sum[6:0]};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 1'b0;
            s_r    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            ovf_r  <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // start_ready is 1 here, so start_valid alone is the accept.
                    if (start_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= opcode;
                        s_r   <= '0;
                        carry <= opcode;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    s_r[bit_off +: 8] <= s_byte;
                    carry             <= c_out_msb;
                    if (idx == LAST_IDX) begin
                        ovf_r  <= c_into_msb ^ c_out_msb;
                        cout_r <= c_out_msb;
                        idx    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                ST_DONE: begin
                    // Result registers are untouched here, so they hold for as
                    // long as the consumer stalls and on into IDLE.
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    // The fourth encoding of the 2-bit state is unreachable;
                    // recover to IDLE if it is ever seen.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags are straight decodes of the state register.
    assign start_ready = (state == ST_IDLE);
    assign res_valid   = (state == ST_DONE);
    assign busy        = (state == ST_RUN) || (state == ST_DONE);
    assign state_dbg   = state;

    assign s           = s_r;
    assign is_overflow = ovf_r;
    assign cout        = cout_r;

endmodule

// File: tb/tb_addsub_seq.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_addsub_seq
//
// Self-checking bench for addsub_seq with BYTES = 4.
// A signed/unsigned integer model gives the expected result of each
// operation; a protocol model (busy flag plus edge count since accept)
// gives the expected handshake outputs every cycle. One compare process
// checks the DUT on every falling edge. Directed operations pin the
// model to hand-computed values, then a long random run with stalls
// exercises everything against the model.
// -----------------------------------------------------------------------------
module tb_addsub_seq;

    localparam int BYTES    = 4;
    localparam int W        = 8 * BYTES;
    localparam int N_RANDOM = 10000;
    localparam int WAIT_MAX = 100;

    // ---------------------------------------------------------------- clock/reset
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         opcode;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] s;
    logic         is_overflow;
    logic         cout;
    logic         busy;
    logic [1:0]   state_dbg;

    addsub_seq #(.BYTES(BYTES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .s           (s),
        .is_overflow (is_overflow),
        .cout        (cout),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // ---------------------------------------------------------------- bookkeeping
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound of %0d cycles expired (t=%0t)", name, WAIT_MAX, $time);
    endtask

    function automatic logic [W-1:0] rnd_w();
        return W'({$urandom, $urandom});
    endfunction

    // ---------------------------------------------------------------- reference model
    // Result packed as {s, is_overflow, cout}. Works on plain integers:
    // overflow = exact signed result outside the W-bit signed range;
    // cout = unsigned sum reaches 2^W (add) or a >= b unsigned (sub).
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic op);
        longint       sx, sy, ux, uy, r, half;
        logic         ov, co;
        logic [W-1:0] sum;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        ux   = longint'(x);
        uy   = longint'(y);
        half = longint'(1) <<< (W - 1);
        r    = op ? (sx - sy) : (sx + sy);
        ov   = (r >= half) || (r < -half);
        co   = op ? (ux >= uy) : ((ux + uy) >= (half <<< 1));
        sum  = W'(r);
        return {sum, ov, co};
    endfunction

    // ---------------------------------------------------------------- scoreboard
    logic [W+1:0] exp_q[$];
    logic [W+1:0] cur_exp    = '0;   // what s/ovf/cout must show when not in RUN
    bit           model_busy = 1'b0; // accepted and not yet handed over
    int           edges      = 0;    // rising edges since the accept edge
    int           n_done     = 0;

    // Compare process: checks current outputs, then predicts the handshakes
    // that the next rising edge will perform from the inputs now stable.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_start_ready", start_ready, 1'b1);
                chk("reset_res_valid", res_valid, 1'b0);
                chk("reset_busy", busy, 1'b0);
                chk("reset_s", s, '0);
                chk("reset_ovf", is_overflow, 1'b0);
                chk("reset_cout", cout, 1'b0);
                chk("reset_state_dbg", state_dbg, 2'd0);
                exp_q.delete();
                model_busy = 1'b0;
                edges      = 0;
                cur_exp    = '0;
            end else begin
                if (model_busy) edges++;
                if (model_busy && edges == BYTES) begin
                    if (exp_q.size() != 0) begin
                        cur_exp = exp_q.pop_front();
                        n_done++;
                    end else begin
                        bound_expired("scoreboard_empty");
                    end
                end
                chk("start_ready", start_ready, !model_busy);
                chk("busy", busy, model_busy);
                chk("res_valid", res_valid, model_busy && edges >= BYTES);
                if (!model_busy || edges >= BYTES) begin
                    chk("result_s", s, cur_exp[W+1:2]);
                    chk("result_ovf", is_overflow, cur_exp[1]);
                    chk("result_cout", cout, cur_exp[0]);
                end
                // Predict the next edge: hand-over or accept, never both.
                if (model_busy) begin
                    if (edges >= BYTES && res_ready) model_busy = 1'b0;
                end else if (start_valid) begin
                    exp_q.push_back(model(a, b, opcode));
                    model_busy = 1'b1;
                    edges      = -1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    // Called at posedge+1. Presents one operation, scrambles the inputs
    // once it is taken, waits for the result and checks it against
    // hand-computed values. Returns at posedge+1 after the first DONE cycle.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic top,
                         input logic [W-1:0] es, input logic eo, input logic ec,
                         input string name);
        int k;
        a           = ta;
        b           = tb2;
        opcode      = top;
        start_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!start_ready && k < WAIT_MAX) begin
            @(negedge clk);
            k++;
        end
        if (k >= WAIT_MAX) begin
            bound_expired({name, "_accept"});
            start_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a           = rnd_w();
        b           = rnd_w();
        opcode      = 1'($urandom_range(0, 1));
        k = 0;
        @(negedge clk);
        while (!res_valid && k < WAIT_MAX) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_latency"}, k, BYTES);
        chk({name, "_s"}, s, es);
        chk({name, "_ovf"}, is_overflow, eo);
        chk({name, "_cout"}, cout, ec);
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int base;
        int cyc;
        int k;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a           = '0;
        b           = '0;
        opcode      = 1'b0;

        // Pin the model itself to hand-computed results.
        chk("model_add_ovf", model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0), {32'h8000_0000, 1'b1, 1'b0});
        chk("model_sub_neg", model(32'h0000_0000, 32'h0000_0001, 1'b1), {32'hFFFF_FFFF, 1'b0, 1'b0});
        chk("model_sub_ovf", model(32'h8000_0000, 32'h0000_0001, 1'b1), {32'h7FFF_FFFF, 1'b1, 1'b1});
        chk("model_add_chain", model(32'h00FF_FFFF, 32'h0000_0001, 1'b0), {32'h0100_0000, 1'b0, 1'b0});
        chk("model_add_wrap", model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0), {32'h0000_0000, 1'b0, 1'b1});
        chk("model_add_plain", model(32'h1234_5678, 32'h1111_1111, 1'b0), {32'h2345_6789, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        res_ready = 1'b1;

        // Directed operations; the first is offered on the first edge after reset.
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0, "add_ovf");
        do_op(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_zero_minus_one");
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_min_minus_one");
        do_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, "add_carry_chain");
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1, "add_wrap");

        // Backpressure: result held through 5 stalled cycles with noisy inputs.
        res_ready = 1'b0;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0, "bp_op");
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            a           = rnd_w();
            b           = rnd_w();
            opcode      = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp_hold_s", s, 32'h8000_0000);
            chk("bp_hold_ovf", is_overflow, 1'b1);
            chk("bp_hold_cout", cout, 1'b0);
            chk("bp_hold_start_ready", start_ready, 1'b0);
            chk("bp_hold_res_valid", res_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        res_ready   = 1'b1;
        start_valid = 1'b1;
        a           = 32'hFFFF_FFFF;
        b           = 32'h0000_0001;
        opcode      = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_start_ready", start_ready, 1'b1);
        chk("bp_release_res_valid", res_valid, 1'b0);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_accept_busy", busy, 1'b1);
        k = 0;
        while (!res_valid && k < WAIT_MAX) begin
            @(negedge clk);
            k++;
        end
        chk("bp_next_s", s, 32'h0000_0000);
        chk("bp_next_cout", cout, 1'b1);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation, after byte 1 is processed.
        a           = 32'h1234_5678;
        b           = 32'h1111_1111;
        opcode      = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_s", s, '0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_res_valid", res_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < BYTES + 3; i++) begin
            @(negedge clk);
            chk("midreset_no_result", res_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "after_reset");

        // Random back-to-back operations with random consumer stalls.
        base = n_done;
        cyc  = 0;
        while ((n_done - base) < N_RANDOM && cyc < 90000) begin
            start_valid = ($urandom_range(0, 7) != 0);
            a           = rnd_w();
            b           = rnd_w();
            opcode      = 1'($urandom_range(0, 1));
            res_ready   = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("random_ops_completed", (n_done - base) >= N_RANDOM, 1'b1);

        // Drain.
        start_valid = 1'b0;
        res_ready   = 1'b1;
        repeat (BYTES + 4) @(posedge clk);
        #1;
        chk("drain_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL be parameterised as: BYTES, 4, operand width in bytes (legal 2..8); W = 8*BYTES derived.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start_valid  input  1  requester presents an operation.
REQ-006 start_ready  output  1  block can accept an operation.
REQ-007 a  input  W  operand A, two's complement.
REQ-008 b  input  W  operand B, two's complement.
REQ-009 opcode  input  1  0 = A+B, 1 = A-B.
REQ-010 res_valid  output  1  result fields valid.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 s  output  W  sum/difference, modulo 2^W.
REQ-013 is_overflow  output  1  signed overflow of the W-bit operation.
REQ-014 cout  output  1  carry out of bit W-1 (for subtract: 1 = no borrow).
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-017 start_ready SHALL be 1 only in IDLE; accept = start_valid && start_ready.
REQ-018 On accept, the block SHALL latch a, b and opcode, clear s, set carry = opcode, set byte index = 0, and enter RUN.
REQ-019 Outside the accept cycle, a/b/opcode SHALL be ignored; start_valid during RUN/DONE has no effect.
REQ-020 In RUN, each cycle SHALL process exactly one byte i (LSB first) using one internal 8-bit slice: {c, s[8i+7:8i]} = a_i + (b_i XOR {8{opcode}}) + carry; carry <= c.
REQ-021 The byte index SHALL increment by 1 per RUN cycle; after byte BYTES-1, the block SHALL enter DONE.
REQ-022 On byte BYTES-1, is_overflow SHALL be set to (carry into bit W-1) XOR (carry out of bit W-1), and cout SHALL be set to the carry out of bit W-1.
REQ-023 res_valid SHALL rise exactly BYTES cycles after the accept edge and be 1 only in DONE.
REQ-024 s, is_overflow and cout SHALL be held stable while res_valid=1 and until the next accept.
REQ-025 In DONE with res_ready=1, the block SHALL enter IDLE on that edge; start_ready SHALL be 1 the following cycle, with no same-cycle result-to-start bypass.
REQ-026 With res_ready=0, DONE SHALL persist indefinitely and outputs SHALL not change.
REQ-027 Throughput SHALL be one operation per BYTES+2 cycles minimum.
REQ-028 An unreachable FSM encoding SHALL return to IDLE on the next edge.

Reset
REQ-029 While rst_n=0, the block SHALL be in IDLE with start_ready=1, res_valid=0, busy=0, s=0, is_overflow=0, cout=0, and carry and index cleared.
REQ-030 rst_n asserted mid-RUN or in DONE SHALL abort the operation immediately, and no res_valid pulse SHALL follow.
REQ-031 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification (BYTES=4)
REQ-032 add 0x7FFFFFFF + 0x00000001 -> s=0x80000000, is_overflow=1, cout=0, res_valid 4 cycles after accept.
REQ-033 sub 0x00000000 - 0x00000001 -> s=0xFFFFFFFF, is_overflow=0, cout=0; sub 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, is_overflow=1, cout=1.
REQ-034 Carry propagation: add 0x00FFFFFF + 0x00000001 -> s=0x01000000, is_overflow=0, cout=0; add 0xFFFFFFFF + 0x00000001 -> s=0, cout=1, is_overflow=0.
REQ-035 Backpressure: hold res_ready=0 for 5 cycles in DONE, with operand inputs toggling and start_valid=1 -> outputs are unchanged and start_ready=0 throughout; with res_ready=1 -> IDLE, then a new accept one cycle later.
REQ-036 Reset mid-op: assert rst_n=0 after byte 1 of a 0x12345678 + 0x11111111 operation -> all outputs are at reset values, and no res_valid occurs; a subsequent 0x12345678 + 0x11111111 -> s=0x23456789.
REQ-037 Random: at least 10k back-to-back operations with random res_ready stalls SHALL match a W-bit reference model for s, is_overflow and cout.
